// File: rtl/digest_out_buffer_pkg.sv
// Shared types and default geometry for the digest output buffer.
// Defaults match a SHA-256 result: eight 32-bit words A..H.
package digest_buf_pkg;

   localparam int DEF_DATA_W    = 32;
   localparam int DEF_NUM_WORDS = 8;
   localparam int DEF_ADDR_W    = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HELD   = 2'd1,
      ST_STREAM = 2'd2
   } buf_state_e;

endpackage

// File: rtl/digest_out_buffer_if.sv
// Load, read and stream handshake bundle for digest_out_buffer.
// The master is the upstream/downstream environment; the slave is the buffer.
interface digest_out_buffer_if
   import digest_buf_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int NUM_WORDS = DEF_NUM_WORDS,
   parameter int ADDR_W    = DEF_ADDR_W
);

   logic                        load;
   logic [NUM_WORDS*DATA_W-1:0] in_words;
   logic                        mode;
   logic [ADDR_W-1:0]           addr;
   logic                        rd_en;
   logic [DATA_W-1:0]           out_var;
   logic                        out_valid;
   logic                        out_ready;
   logic                        out_last;
   logic                        held;
   logic                        overrun;

   modport master (
      output load, in_words, mode, addr, rd_en, out_ready,
      input  out_var, out_valid, out_last, held, overrun
   );

   modport slave (
      input  load, in_words, mode, addr, rd_en, out_ready,
      output out_var, out_valid, out_last, held, overrun
   );

endinterface

// File: rtl/digest_out_buffer_word_sel.sv
// Index-to-word mux over the flattened store; indices past the last word yield 0.
// One instance serves both the addressed-read and the stream paths.
module digest_word_sel #(
   parameter int DATA_W    = 32,
   parameter int NUM_WORDS = 8,
   parameter int ADDR_W    = 4
) (
   input  logic [NUM_WORDS*DATA_W-1:0] words,
   input  logic [ADDR_W-1:0]           index,
   output logic [DATA_W-1:0]           word
);

   always_comb begin
      word = '0;
      for (int k = 0; k < NUM_WORDS; k++) begin
         if (index == ADDR_W'(k)) word = words[k*DATA_W +: DATA_W];
      end
   end

endmodule

// File: rtl/digest_out_buffer.sv
// Holds one captured digest and serves it either by addressed reads or as a
// valid/ready word stream ending with out_last.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | nothing captured (or stream finished); reads ignored
// ST_HELD   | digest captured; addressed reads answered with latency 1
// ST_STREAM | digest being streamed word by word; loads rejected
module digest_out_buffer
   import digest_buf_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int NUM_WORDS = DEF_NUM_WORDS,
   parameter int ADDR_W    = DEF_ADDR_W
) (
   input  logic               clk,
   input  logic               rst,
   digest_out_buffer_if.slave bus
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);

   buf_state_e                  state_q, state_d;
   logic [ADDR_W-1:0]           idx_q, idx_d;
   logic [NUM_WORDS*DATA_W-1:0] store_q;
   logic                        rd_valid_q;
   logic [DATA_W-1:0]           rd_data_q;
   logic                        overrun_q;

   logic                        last_hs;
   logic                        load_accept;
   logic                        load_reject;
   logic                        rd_fire;
   logic [ADDR_W-1:0]           sel_index;
   logic [DATA_W-1:0]           sel_word;

   assign sel_index = (state_q == ST_STREAM) ? idx_q : bus.addr;

   digest_word_sel #(
      .DATA_W    (DATA_W),
      .NUM_WORDS (NUM_WORDS),
      .ADDR_W    (ADDR_W)
   ) u_word_sel (
      .words (store_q),
      .index (sel_index),
      .word  (sel_word)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      last_hs     = 1'b0;
      load_accept = 1'b0;
      load_reject = 1'b0;
      rd_fire     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            load_accept = bus.load;
         end
         ST_HELD: begin
            load_accept = bus.load;
            rd_fire     = bus.rd_en;
         end
         ST_STREAM: begin
            last_hs = bus.out_ready && (idx_q == LAST_IDX);
            if (last_hs) begin
               state_d     = ST_IDLE;
               idx_d       = '0;
               load_accept = bus.load;
            end else begin
               if (bus.out_ready) idx_d = idx_q + ADDR_W'(1);
               load_reject = bus.load;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // A finishing stream hands over to the new load in the same cycle.
      if (load_accept) begin
         state_d = bus.mode ? ST_STREAM : ST_HELD;
         idx_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         store_q    <= '0;
         idx_q      <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         overrun_q  <= 1'b0;
      end else begin
         if (load_accept) store_q <= bus.in_words;
         idx_q      <= idx_d;
         rd_valid_q <= rd_fire;
         rd_data_q  <= rd_fire ? sel_word : '0;
         if (load_reject) overrun_q <= 1'b1;
      end
   end

   always_comb begin
      bus.out_var   = '0;
      bus.out_valid = 1'b0;
      bus.out_last  = 1'b0;
      bus.held      = (state_q != ST_IDLE);
      bus.overrun   = overrun_q;
      if (state_q == ST_STREAM) begin
         bus.out_var   = sel_word;
         bus.out_valid = 1'b1;
         bus.out_last  = (idx_q == LAST_IDX);
      end else if (rd_valid_q) begin
         bus.out_var   = rd_data_q;
         bus.out_valid = 1'b1;
      end
   end

endmodule

// File: tb/tb_digest_out_buffer.sv
// Directed checks of digest_out_buffer: reset, addressed reads, streaming,
// backpressure with overrun, load on last handshake and mid-stream reset.
module tb_digest_out_buffer;
   import digest_buf_pkg::*;

   localparam int DW = 32;
   localparam int NW = 8;
   localparam int AW = 4;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;

   logic [NW*DW-1:0] pat_a, pat_b, pat_c;
   int               va[NW] = '{1, 2, 3, 4, 55, 6, 7, 8};
   int               vb[NW] = '{11, 12, 13, 14, 15, 16, 17, 18};

   digest_out_buffer_if #(.DATA_W(DW), .NUM_WORDS(NW), .ADDR_W(AW)) bus ();

   digest_out_buffer #(.DATA_W(DW), .NUM_WORDS(NW), .ADDR_W(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.load = 1'b0; bus.mode = 1'b0; bus.rd_en = 1'b0;
      bus.addr = '0;   bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      bus.in_words = pat_a;
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_cmp++;
      if ({bus.held, bus.overrun, bus.out_valid, bus.out_last, bus.out_var} !== 36'h0) begin
         n_err++;
         $display("FAIL reset_outputs: got %h want 0",
                  {bus.held, bus.overrun, bus.out_valid, bus.out_last, bus.out_var});
      end
      bus.rd_en = 1'b1; bus.addr = 4'd1;
      step();
      bus.rd_en = 1'b0;
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin
         n_err++; $display("FAIL idle_rd_ignored: valid=%b want 0", bus.out_valid);
      end
   endtask

   task automatic test_addressed();
      bus.in_words = pat_a; bus.mode = 1'b0; bus.load = 1'b1;
      step();
      bus.load = 1'b0;
      n_cmp++;
      if ({bus.held, bus.out_valid, bus.out_last} !== 3'b100) begin
         n_err++; $display("FAIL held_after_load: got %b want 100",
                           {bus.held, bus.out_valid, bus.out_last});
      end
      bus.rd_en = 1'b1; bus.addr = 4'd1;
      step();
      n_cmp++;
      if ({bus.out_valid, bus.out_var} !== {1'b1, 32'd2}) begin
         n_err++; $display("FAIL rd_addr1: valid=%b var=%0d want 1/2", bus.out_valid, bus.out_var);
      end
      bus.addr = 4'd5;
      step();
      bus.rd_en = 1'b0;
      n_cmp++;
      if ({bus.out_valid, bus.out_var} !== {1'b1, 32'd6}) begin
         n_err++; $display("FAIL rd_addr5: valid=%b var=%0d want 1/6", bus.out_valid, bus.out_var);
      end
      step();
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin
         n_err++; $display("FAIL rd_single_cycle: valid=%b want 0", bus.out_valid);
      end
   endtask

   task automatic test_out_of_range();
      bus.rd_en = 1'b1; bus.addr = 4'd12;
      step();
      n_cmp++;
      if ({bus.out_valid, bus.out_var} !== {1'b1, 32'd0}) begin
         n_err++; $display("FAIL rd_addr12: valid=%b var=%0d want 1/0", bus.out_valid, bus.out_var);
      end
      bus.addr = 4'd4;
      step();
      bus.rd_en = 1'b0;
      n_cmp++;
      if ({bus.out_valid, bus.out_var} !== {1'b1, 32'd55}) begin
         n_err++; $display("FAIL rd_addr4: valid=%b var=%0d want 1/55", bus.out_valid, bus.out_var);
      end
      // mode toggled without a load must not start a stream
      bus.mode = 1'b1;
      step();
      step();
      bus.mode = 1'b0;
      n_cmp++;
      if ({bus.held, bus.out_valid, bus.out_last} !== 3'b100) begin
         n_err++; $display("FAIL mode_no_effect: got %b want 100",
                           {bus.held, bus.out_valid, bus.out_last});
      end
   endtask

   task automatic test_stream();
      bus.in_words = pat_a; bus.mode = 1'b1; bus.load = 1'b1; bus.out_ready = 1'b1;
      step();
      bus.load = 1'b0; bus.mode = 1'b0;
      for (int i = 0; i < NW; i++) begin
         n_cmp++;
         if ({bus.out_valid, bus.out_last, bus.out_var} !== {1'b1, (i == NW-1), va[i]}) begin
            n_err++; $display("FAIL stream_word%0d: valid=%b last=%b var=%0d want 1/%0d/%0d",
                              i, bus.out_valid, bus.out_last, bus.out_var, (i == NW-1), va[i]);
         end
         step();
      end
      n_cmp++;
      if ({bus.held, bus.out_valid, bus.out_last} !== 3'b000) begin
         n_err++; $display("FAIL stream_end: got %b want 000",
                           {bus.held, bus.out_valid, bus.out_last});
      end
      bus.out_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      bus.in_words = pat_a; bus.mode = 1'b1; bus.load = 1'b1; bus.out_ready = 1'b1;
      step();
      bus.load = 1'b0; bus.mode = 1'b0;
      step();
      step();
      bus.out_ready = 1'b0;
      bus.in_words = pat_c; bus.load = 1'b1;
      for (int c = 0; c < 3; c++) begin
         n_cmp++;
         if ({bus.out_valid, bus.out_last, bus.out_var} !== {1'b1, 1'b0, 32'd3}) begin
            n_err++; $display("FAIL stall_cycle%0d: valid=%b last=%b var=%0d want 1/0/3",
                              c, bus.out_valid, bus.out_last, bus.out_var);
         end
         step();
         bus.load = 1'b0;
      end
      n_cmp++;
      if (bus.overrun !== 1'b1) begin
         n_err++; $display("FAIL overrun_set: got %b want 1", bus.overrun);
      end
      bus.out_ready = 1'b1;
      for (int i = 2; i < NW; i++) begin
         n_cmp++;
         if ({bus.out_valid, bus.out_var} !== {1'b1, va[i]}) begin
            n_err++; $display("FAIL resume_word%0d: valid=%b var=%0d want 1/%0d",
                              i, bus.out_valid, bus.out_var, va[i]);
         end
         step();
      end
      bus.out_ready = 1'b0;
      n_cmp++;
      if ({bus.out_valid, bus.overrun} !== 2'b01) begin
         n_err++; $display("FAIL overrun_sticky: valid/overrun=%b want 01",
                           {bus.out_valid, bus.overrun});
      end
   endtask

   task automatic test_load_on_last();
      idle_inputs();
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.in_words = pat_a; bus.mode = 1'b1; bus.load = 1'b1; bus.out_ready = 1'b1;
      step();
      bus.load = 1'b0;
      for (int i = 0; i < NW-1; i++) step();
      bus.in_words = pat_b; bus.load = 1'b1;
      n_cmp++;
      if ({bus.out_last, bus.out_var} !== {1'b1, 32'd8}) begin
         n_err++; $display("FAIL last_before_reload: last=%b var=%0d want 1/8",
                           bus.out_last, bus.out_var);
      end
      step();
      bus.load = 1'b0;
      n_cmp++;
      if ({bus.overrun, bus.out_valid, bus.out_last, bus.out_var} !== {3'b010, 32'd11}) begin
         n_err++; $display("FAIL reload_on_last: ovr=%b valid=%b last=%b var=%0d want 0/1/0/11",
                           bus.overrun, bus.out_valid, bus.out_last, bus.out_var);
      end
      step();
      n_cmp++;
      if (bus.out_var !== vb[1]) begin
         n_err++; $display("FAIL reload_word1: var=%0d want %0d", bus.out_var, vb[1]);
      end
   endtask

   task automatic test_reset_mid_stream();
      idle_inputs();
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.in_words = pat_a; bus.mode = 1'b1; bus.load = 1'b1; bus.out_ready = 1'b1;
      step();
      bus.load = 1'b0;
      step(); step(); step();
      n_cmp++;
      if (bus.out_var !== 32'd4) begin
         n_err++; $display("FAIL pre_reset_word: var=%0d want 4", bus.out_var);
      end
      rst = 1'b1; bus.load = 1'b1; bus.rd_en = 1'b1;
      step();
      rst = 1'b0; bus.load = 1'b0;
      n_cmp++;
      if ({bus.held, bus.overrun, bus.out_valid, bus.out_last, bus.out_var} !== 36'h0) begin
         n_err++; $display("FAIL mid_stream_reset: got %h want 0",
                           {bus.held, bus.overrun, bus.out_valid, bus.out_last, bus.out_var});
      end
      bus.addr = 4'd0;
      step();
      n_cmp++;
      if ({bus.held, bus.out_valid} !== 2'b00) begin
         n_err++; $display("FAIL rd_after_reset: held/valid=%b want 00", {bus.held, bus.out_valid});
      end
      idle_inputs();
   endtask

   initial begin
      for (int i = 0; i < NW; i++) begin
         pat_a[i*DW +: DW] = DW'(va[i]);
         pat_b[i*DW +: DW] = DW'(vb[i]);
         pat_c[i*DW +: DW] = 32'h9999_0000 + DW'(i);
      end
      rst = 1'b1;
      idle_inputs();
      bus.in_words = '0;
      step();
      test_reset();
      test_addressed();
      test_out_of_range();
      test_stream();
      test_backpressure();
      test_load_on_last();
      test_reset_mid_stream();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/digest_out_buffer.md
DIGEST_OUT_BUFFER -- requirements
Module: digest_out_buffer

Interface
REQ-001 Parameter DATA_W, default 32, word width in bits.
REQ-002 Parameter NUM_WORDS, default 8, words captured per load (A..H for SHA-256).
REQ-003 Parameter ADDR_W, default 4, address width; SHALL satisfy 2**ADDR_W >= NUM_WORDS.
REQ-004 clk  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 load  in  1  capture strobe for all words.
REQ-007 in_words  in  NUM_WORDS*DATA_W  word i at bits [i*DATA_W +: DATA_W]; word 0 = A.
REQ-008 mode  in  1  0 = addressed read, 1 = streamed read; sampled only on an accepted load.
REQ-009 addr  in  ADDR_W  word index for addressed read.
REQ-010 rd_en  in  1  addressed read request.
REQ-011 out_var  out  DATA_W  output word.
REQ-012 out_valid  out  1  out_var carries a valid word.
REQ-013 out_ready  in  1  downstream accepts the word in stream mode.
REQ-014 out_last  out  1  high with word NUM_WORDS-1 in stream mode.
REQ-015 held  out  1  high when the store holds loaded data (state HELD or STREAM).
REQ-016 overrun  out  1  sticky; a load was rejected.

Function
REQ-017 FSM states SHALL be IDLE, HELD, STREAM.
REQ-018 Accepted load SHALL capture all NUM_WORDS words in one cycle; captured data visible from the next cycle.
REQ-019 Load SHALL be accepted in IDLE and HELD; next state HELD if mode=0, STREAM if mode=1.
REQ-020 Load in STREAM SHALL be rejected, store unchanged, and overrun set to 1 next cycle; exception: see REQ-026.
REQ-021 HELD, rd_en=1, addr<NUM_WORDS: next cycle out_var=word[addr], out_valid=1 for exactly one cycle (latency 1).
REQ-022 HELD, rd_en=1, addr>=NUM_WORDS: next cycle out_var=0, out_valid=1 for one cycle.
REQ-023 rd_en SHALL be ignored in IDLE and STREAM; out_valid=0 when no read issued.
REQ-024 STREAM entry: word index=0; out_valid=1, out_var=word[index] from the cycle after load.
REQ-025 STREAM: out_var, out_valid and out_last SHALL hold stable while out_valid=1 and out_ready=0; on out_valid&out_ready, index increments and the next word appears the following cycle (zero-bubble).
REQ-026 Handshake on last word -> IDLE, out_valid=0 next cycle; if load=1 in that same cycle, load SHALL be accepted (no overrun), restarting per REQ-019.
REQ-027 out_last SHALL be 1 only in STREAM with index=NUM_WORDS-1; 0 in all other states.
REQ-028 HELD remains until next load or rst; data may be read any number of times.
REQ-029 mode changes outside an accepted load SHALL have no effect.

Reset
REQ-030 rst=1 SHALL on the next edge force state IDLE, index 0, all stored words 0, out_var 0, out_valid 0, out_last 0, held 0, overrun 0.
REQ-031 rst SHALL take priority over load, rd_en and handshake, including mid-stream; no partial word emitted after reset.

Structure
REQ-032 Package digest_buf_pkg SHALL hold the FSM state typedef and default DATA_W/NUM_WORDS/ADDR_W constants.
REQ-033 Word selection SHALL be one sub-module, digest_word_sel (index -> word mux, out-of-range returns 0), shared by addressed and stream paths.
REQ-034 Total RTL 120-400 lines; no multi-cycle combinational paths beyond the word mux.

Verification
REQ-035 Load {1,2,3,4,55,6,7,8}, mode=0; rd_en addr=1 -> next cycle out_var=2, out_valid=1; addr=5 -> out_var=6.
REQ-036 HELD, rd_en addr=12 -> out_var=0, out_valid=1 one cycle; store unchanged (addr=4 then returns 55).
REQ-037 Load {1..8 pattern above}, mode=1, out_ready=1 -> 8 consecutive words 1,2,3,4,55,6,7,8, out_last only on 8, then out_valid=0.
REQ-038 Stream, out_ready=0 for 3 cycles on word 3 -> out_var=3 held stable; a load during STREAM -> overrun=1, stream continues with original data.
REQ-039 Load coincident with last handshake -> no overrun, new stream starts at word 0 next cycle.
REQ-040 rst asserted mid-stream at word 4 -> next cycle all outputs 0, state IDLE; rd_en ignored until next load.
